// File: rtl/hazard_ctrl_if.sv
// ============================================================================
// Module : hazard_ctrl_if
// Brief  : Pipeline-side bundle between the datapath and the hazard controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface hazard_ctrl_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
);
    logic [REG_ADDR_WIDTH-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic                      RegWriteM, RegWriteW;
    logic [1:0]                ResultSrcE;
    logic                      PCSrcE;
    logic                      MemReqM, MemReadyM;
    logic [1:0]                ForwardAE, ForwardBE;
    logic                      StallF, StallD, StallE, StallM, StallW;
    logic                      FlushD, FlushE;
    logic                      mem_err;
    logic [CNT_WIDTH-1:0]      cyc_cnt, stall_cnt, flush_cnt;

    // Pipeline datapath side
    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW,
        input  FlushD, FlushE, mem_err, cyc_cnt, stall_cnt, flush_cnt
    );

    // Hazard controller side
    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, StallW,
        output FlushD, FlushE, mem_err, cyc_cnt, stall_cnt, flush_cnt
    );
endinterface

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module : hazard_ctrl
// Brief  : 5-stage pipeline hazard controller: forwarding, load-use stall,
//          branch flush, memory-wait freeze with timeout halt.
//          Optional performance counters enabled by `define HAZARD_PERF_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_TIMEOUT    = 15,
    parameter int CNT_WIDTH      = 32
) (
    input  wire logic    clk,
    input  wire logic    rst,
    hazard_ctrl_if.slave bus
);

    localparam int                        c_WAIT_W  = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0]       c_TIMEOUT = c_WAIT_W'(MEM_TIMEOUT);
    localparam logic [REG_ADDR_WIDTH-1:0] c_X0      = '0;

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_mem_err;

    logic [1:0] w_fwd_a, w_fwd_b;
    logic       w_lw_stall, w_freeze;
    logic       w_stall_f, w_stall_d, w_stall_e, w_stall_m, w_stall_w;
    logic       w_flush_d, w_flush_e;

    always_comb begin
        w_fwd_a = 2'b00;
        if (bus.RegWriteM && bus.RdM != c_X0 && bus.RdM == bus.Rs1E)
            w_fwd_a = 2'b10;
        else if (bus.RegWriteW && bus.RdW != c_X0 && bus.RdW == bus.Rs1E)
            w_fwd_a = 2'b01;

        w_fwd_b = 2'b00;
        if (bus.RegWriteM && bus.RdM != c_X0 && bus.RdM == bus.Rs2E)
            w_fwd_b = 2'b10;
        else if (bus.RegWriteW && bus.RdW != c_X0 && bus.RdW == bus.Rs2E)
            w_fwd_b = 2'b01;

        if (rst) begin
            w_fwd_a = 2'b00;
            w_fwd_b = 2'b00;
        end
    end

    assign w_lw_stall = (bus.ResultSrcE == 2'b01) && (bus.RdE != c_X0) &&
                        ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));
    assign w_freeze   = (bus.MemReqM && !bus.MemReadyM) || (r_state == S_HALT);

    // Priority: reset > freeze > taken branch > load-use
    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_stall_m = 1'b0;
        w_stall_w = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        if (rst) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (w_freeze) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
            w_stall_w = 1'b1;
        end else if (bus.PCSrcE) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if (w_lw_stall) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
        end
    end

    // r_wait_cnt holds the number of WAIT cycles already spent, including this one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (bus.MemReqM && !bus.MemReadyM) begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= c_WAIT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (bus.MemReadyM) begin
                        r_state    <= S_RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == c_TIMEOUT) begin
                        r_state   <= S_HALT;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                S_HALT: r_state <= S_HALT;
                default: begin
                    r_state    <= S_RUN;
                    r_wait_cnt <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [CNT_WIDTH-1:0] r_cyc_cnt, r_stall_cnt, r_flush_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cyc_cnt   <= '0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 1'b1;
            if (w_stall_f)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (bus.PCSrcE && !w_freeze)
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign bus.cyc_cnt   = r_cyc_cnt;
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
`else
    assign bus.cyc_cnt   = {CNT_WIDTH{1'b0}};
    assign bus.stall_cnt = {CNT_WIDTH{1'b0}};
    assign bus.flush_cnt = {CNT_WIDTH{1'b0}};
`endif

    assign bus.ForwardAE = w_fwd_a;
    assign bus.ForwardBE = w_fwd_b;
    assign bus.StallF    = w_stall_f;
    assign bus.StallD    = w_stall_d;
    assign bus.StallE    = w_stall_e;
    assign bus.StallM    = w_stall_m;
    assign bus.StallW    = w_stall_w;
    assign bus.FlushD    = w_flush_d;
    assign bus.FlushE    = w_flush_e;
    assign bus.mem_err   = r_mem_err;

endmodule

`default_nettype wire
